// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle RV32I core: sequences each instruction and
// drives every datapath select, write enable and memory request.
module multicycle_ctrl #(
   parameter bit TRAP_HALT     = 1'b1,
   parameter bit STRICT_DECODE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   input  logic       lt,
   input  logic       ltu,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       mem_read,
   output logic       mem_write,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [3:0] alu_control,
   output logic [2:0] imm_src,
   output logic [1:0] mem_size,
   output logic       mem_unsigned,
   output logic       illegal,
   output logic [3:0] state_o
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_JAL      = 4'd9,
      S_JALR     = 4'd10,
      S_BRANCH   = 4'd11,
      S_UPPER    = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   state_t     state, state_nxt;
   logic       bad_fn;
   logic       br_taken;
   logic [3:0] alu_fn;
   logic       pc_w, ir_w, reg_w, mem_rd, mem_wr;

   // Opcode is known-good but the funct fields select an encoding RV32I leaves undefined
   always_comb begin
      bad_fn = 1'b0;
      case (op)
         OP_LOAD:  bad_fn = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         OP_STORE: bad_fn = funct3[2] || (funct3 == 3'b011);
         OP_BR:    bad_fn = (funct3[2:1] == 2'b01);
         OP_JALR:  bad_fn = (funct3 != 3'b000);
         OP_R: begin
            if (STRICT_DECODE)
               bad_fn = !((funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         OP_I: begin
            if (STRICT_DECODE) begin
               if (funct3 == 3'b001)
                  bad_fn = (funct7 != 7'b0000000);
               else if (funct3 == 3'b101)
                  bad_fn = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end
         end
         default: bad_fn = 1'b0;
      endcase
   end

   always_comb begin
      alu_fn = ALU_ADD;
      case (funct3)
         3'b000:  alu_fn = ((op == OP_R) && funct7[5]) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_fn = ALU_SLL;
         3'b010:  alu_fn = ALU_SLT;
         3'b011:  alu_fn = ALU_SLTU;
         3'b100:  alu_fn = ALU_XOR;
         3'b101:  alu_fn = funct7[5] ? ALU_SRA : ALU_SRL;
         3'b110:  alu_fn = ALU_OR;
         default: alu_fn = ALU_AND;
      endcase
   end

   // funct3[0] inverts the base condition (bne/bge/bgeu)
   always_comb begin
      br_taken = 1'b0;
      case (funct3[2:1])
         2'b00:   br_taken = zero;
         2'b10:   br_taken = lt;
         2'b11:   br_taken = ltu;
         default: br_taken = 1'b0;
      endcase
      br_taken = br_taken ^ funct3[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
               OP_R:              state_nxt = S_EXECR;
               OP_I:              state_nxt = S_EXECI;
               OP_JAL:            state_nxt = S_JAL;
               OP_JALR:           state_nxt = S_JALR;
               OP_BR:             state_nxt = S_BRANCH;
               OP_LUI, OP_AUIPC:  state_nxt = S_UPPER;
               default:           state_nxt = S_TRAP;
            endcase
            if (bad_fn) state_nxt = S_TRAP;
         end
         S_MEMADR:   state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_nxt = S_FETCH;
         S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECR:    state_nxt = S_ALUWB;
         S_EXECI:    state_nxt = S_ALUWB;
         S_ALUWB:    state_nxt = S_FETCH;
         S_JALR:     state_nxt = S_JAL;
         S_JAL:      state_nxt = S_ALUWB;
         S_BRANCH:   state_nxt = S_FETCH;
         S_UPPER:    state_nxt = S_ALUWB;
         S_TRAP:     state_nxt = TRAP_HALT ? S_TRAP : S_FETCH;
         default:    state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      pc_w        = 1'b0;
      ir_w        = 1'b0;
      reg_w       = 1'b0;
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (state)
         S_FETCH: begin
            mem_rd     = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            ir_w       = mem_ready;
            pc_w       = mem_ready;
         end
         // OldPC + imm precomputes the branch/jal target into ALUOut
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            mem_rd  = 1'b1;
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
         end
         S_MEMWRITE: begin
            mem_wr  = 1'b1;
            adr_src = 1'b1;
         end
         S_EXECR: begin
            alu_src_a   = 2'b10;
            alu_control = alu_fn;
         end
         S_EXECI: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_fn;
         end
         S_ALUWB: reg_w = 1'b1;
         S_JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         // PC takes the target from ALUOut while the ALU forms the link OldPC+4
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_w      = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a   = 2'b10;
            alu_control = ALU_SUB;
            pc_w        = br_taken;
         end
         S_UPPER: begin
            alu_src_a = op[5] ? 2'b11 : 2'b01;
            alu_src_b = 2'b01;
         end
         S_TRAP:  illegal = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      imm_src = 3'b000;
      case (op)
         OP_LOAD, OP_JALR, OP_I: imm_src = 3'b000;
         OP_STORE:               imm_src = 3'b001;
         OP_BR:                  imm_src = 3'b010;
         OP_JAL:                 imm_src = 3'b011;
         OP_LUI, OP_AUIPC:       imm_src = 3'b100;
         default:                imm_src = 3'b000;
      endcase
   end

   // Write enables are held off combinationally for the whole reset pulse
   assign pc_write     = pc_w   & rst_n;
   assign ir_write     = ir_w   & rst_n;
   assign reg_write    = reg_w  & rst_n;
   assign mem_read     = mem_rd & rst_n;
   assign mem_write    = mem_wr & rst_n;
   assign mem_size     = funct3[1:0];
   assign mem_unsigned = funct3[2];
   assign state_o      = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expectations are queued per
// instruction, then popped and compared on the falling edge.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       zero, lt, ltu, mem_ready;
   logic       pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
   logic [1:0] alu_src_a, alu_src_b, result_src, mem_size;
   logic [3:0] alu_control, state_o;
   logic [2:0] imm_src;
   logic       mem_unsigned, illegal;

   multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
      .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
      .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .adr_src(adr_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
      .alu_control(alu_control), .imm_src(imm_src), .mem_size(mem_size),
      .mem_unsigned(mem_unsigned), .illegal(illegal), .state_o(state_o)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // en = {pc_write, ir_write, reg_write, mem_read, mem_write, illegal}
   typedef struct {
      logic [3:0] st;
      logic [5:0] en;
      logic       adr;
      logic [1:0] a, b, rs;
      logic [3:0] alu;
      logic [2:0] imm;
      logic       rdy;
   } exp_t;

   exp_t       sb[$];
   int         n_chk = 0;
   int         n_fail = 0;
   logic [2:0] cur_imm;
   string      cur_name;
   wire  [5:0] en_obs = {pc_write, ir_write, reg_write, mem_read, mem_write, illegal};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void px(input int st, input int en, input int adr, input int a,
                              input int b, input int rs, input int alu, input int rdy);
      exp_t e;
      e.st  = 4'(st);
      e.en  = 6'(en);
      e.adr = 1'(adr);
      e.a   = 2'(a);
      e.b   = 2'(b);
      e.rs  = 2'(rs);
      e.alu = 4'(alu);
      e.imm = cur_imm;
      e.rdy = 1'(rdy);
      sb.push_back(e);
   endfunction

   // mem_ready is a don't-care outside the memory states, so it is randomised there
   function automatic int ran();
      return int'($urandom_range(0, 1));
   endfunction

   function automatic void ef(input int rdy);
      px(0, rdy != 0 ? 'b110100 : 'b000100, 0, 0, 2, 2, 0, rdy);
   endfunction
   function automatic void ed();
      px(1, 0, 0, 1, 1, 0, 0, ran());
   endfunction
   function automatic void ew();
      px(8, 'b001000, 0, 0, 0, 0, 0, ran());
   endfunction
   function automatic void e_memadr();
      px(2, 0, 0, 2, 1, 0, 0, ran());
   endfunction
   function automatic void e_trap();
      px(13, 'b000001, 0, 0, 0, 0, 0, ran());
   endfunction

   task automatic instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [2:0] imm);
      cur_name = name;
      op       = o;
      funct3   = f3;
      funct7   = f7;
      cur_imm  = imm;
   endtask

   // Called just after a rising edge; each entry covers one clock cycle
   task automatic run();
      exp_t e;
      int   cyc;
      cyc = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         mem_ready = e.rdy;
         @(negedge clk);
         check($sformatf("%s[%0d].state", cur_name, cyc), 32'(state_o), 32'(e.st));
         check($sformatf("%s[%0d].en", cur_name, cyc), 32'(en_obs), 32'(e.en));
         check($sformatf("%s[%0d].adr_src", cur_name, cyc), 32'(adr_src), 32'(e.adr));
         check($sformatf("%s[%0d].src_a", cur_name, cyc), 32'(alu_src_a), 32'(e.a));
         check($sformatf("%s[%0d].src_b", cur_name, cyc), 32'(alu_src_b), 32'(e.b));
         check($sformatf("%s[%0d].result_src", cur_name, cyc), 32'(result_src), 32'(e.rs));
         check($sformatf("%s[%0d].alu", cur_name, cyc), 32'(alu_control), 32'(e.alu));
         check($sformatf("%s[%0d].imm_src", cur_name, cyc), 32'(imm_src), 32'(e.imm));
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   // Asynchronous reset between edges: state must drop to FETCH at once
   task automatic reset_pulse(input string tag);
      mem_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      check({tag, ".rst_state"}, 32'(state_o), 32'd0);
      check({tag, ".rst_en"}, 32'(en_obs), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check({tag, ".rst_state_hold"}, 32'(state_o), 32'd0);
      check({tag, ".rst_en_hold"}, 32'(en_obs), 32'd0);
      mem_ready = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      op = OP_LOAD; funct3 = 3'b010; funct7 = 7'd0; cur_imm = 3'b000; cur_name = "init";
      #2;
      check("reset.state", 32'(state_o), 32'd0);
      check("reset.en", 32'(en_obs), 32'd0);
      @(negedge clk);
      check("reset.en_clocked", 32'(en_obs), 32'd0);
      mem_ready = 1'b0;
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      instr("add", OP_R, 3'b000, 7'h00, 3'b000);
      ef(1); ed(); px(6, 0, 0, 2, 0, 0, 0, ran()); ew(); run();
      instr("sub", OP_R, 3'b000, 7'h20, 3'b000);
      ef(1); ed(); px(6, 0, 0, 2, 0, 0, 1, ran()); ew(); run();
      instr("sltu", OP_R, 3'b011, 7'h00, 3'b000);
      ef(1); ed(); px(6, 0, 0, 2, 0, 0, 6, ran()); ew(); run();
      instr("sra", OP_R, 3'b101, 7'h20, 3'b000);
      ef(1); ed(); px(6, 0, 0, 2, 0, 0, 9, ran()); ew(); run();
      instr("ori", OP_I, 3'b110, 7'h00, 3'b000);
      ef(1); ed(); px(7, 0, 0, 2, 1, 0, 3, ran()); ew(); run();
      instr("srai", OP_I, 3'b101, 7'h20, 3'b000);
      ef(1); ed(); px(7, 0, 0, 2, 1, 0, 9, ran()); ew(); run();

      // 2 fetch waits + 3 read waits -> 10 cycles, single ir_write
      instr("lw", OP_LOAD, 3'b010, 7'h00, 3'b000);
      ef(0); ef(0); ef(1); ed(); e_memadr();
      repeat (3) px(3, 'b000100, 1, 0, 0, 0, 0, 0);
      px(3, 'b000100, 1, 0, 0, 0, 0, 1);
      px(4, 'b001000, 0, 0, 0, 1, 0, ran());
      run();
      check("lw.mem_size", 32'(mem_size), 32'd2);
      check("lw.mem_unsigned", 32'(mem_unsigned), 32'd0);

      instr("lhu", OP_LOAD, 3'b101, 7'h00, 3'b000);
      ef(1); ed(); e_memadr(); px(3, 'b000100, 1, 0, 0, 0, 0, 1);
      px(4, 'b001000, 0, 0, 0, 1, 0, ran()); run();
      check("lhu.mem_size", 32'(mem_size), 32'd1);
      check("lhu.mem_unsigned", 32'(mem_unsigned), 32'd1);

      instr("sw", OP_STORE, 3'b010, 7'h00, 3'b001);
      ef(1); ed(); e_memadr();
      px(5, 'b000010, 1, 0, 0, 0, 0, 0); px(5, 'b000010, 1, 0, 0, 0, 0, 1); run();

      instr("bge_nt", OP_BR, 3'b101, 7'h00, 3'b010); lt = 1'b1;
      ef(1); ed(); px(11, 0, 0, 2, 0, 0, 1, ran()); run();
      instr("bge_t", OP_BR, 3'b101, 7'h00, 3'b010); lt = 1'b0;
      ef(1); ed(); px(11, 'b100000, 0, 2, 0, 0, 1, ran()); run();
      instr("beq_t", OP_BR, 3'b000, 7'h00, 3'b010); zero = 1'b1;
      ef(1); ed(); px(11, 'b100000, 0, 2, 0, 0, 1, ran()); run();
      instr("bltu_nt", OP_BR, 3'b110, 7'h00, 3'b010); zero = 1'b0; ltu = 1'b0;
      ef(1); ed(); px(11, 0, 0, 2, 0, 0, 1, ran()); run();

      instr("jalr", OP_JALR, 3'b000, 7'h00, 3'b000);
      ef(1); ed(); px(10, 0, 0, 2, 1, 0, 0, ran()); px(9, 'b100000, 0, 1, 2, 0, 0, ran()); ew(); run();
      instr("jal", OP_JAL, 3'b011, 7'h12, 3'b011);
      ef(1); ed(); px(9, 'b100000, 0, 1, 2, 0, 0, ran()); ew(); run();
      instr("lui", OP_LUI, 3'b111, 7'h3f, 3'b100);
      ef(1); ed(); px(12, 0, 0, 3, 1, 0, 0, ran()); ew(); run();
      instr("auipc", OP_AUIPC, 3'b001, 7'h01, 3'b100);
      ef(1); ed(); px(12, 0, 0, 1, 1, 0, 0, ran()); ew(); run();

      instr("r_bad_f7", OP_R, 3'b001, 7'h20, 3'b000);
      ef(1); ed(); repeat (3) e_trap(); run();
      reset_pulse("r_bad_f7");
      instr("ld_bad_f3", OP_LOAD, 3'b011, 7'h00, 3'b000);
      ef(1); ed(); repeat (2) e_trap(); run();
      reset_pulse("ld_bad_f3");
      instr("br_bad_f3", OP_BR, 3'b010, 7'h00, 3'b010);
      ef(1); ed(); repeat (2) e_trap(); run();
      reset_pulse("br_bad_f3");

      instr("lw_rst", OP_LOAD, 3'b010, 7'h00, 3'b000);
      ef(1); ed(); e_memadr(); px(3, 'b000100, 1, 0, 0, 0, 0, 0); run();
      reset_pulse("lw_rst");

      instr("halt", 7'b0000000, 3'b000, 7'h00, 3'b000);
      ef(1); ed(); repeat (20) e_trap(); run();
      reset_pulse("halt");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
